// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the TRNG sampling sequencer.
//   trng_state_t  - sequencer states (IDLE, WARMUP, SAMPLE, HOLD, FAULT)
//   BYTE_W        - width of a delivered random byte
//   DEF_*         - default parameter values for trng_sample_ctrl
//   cnt_w()       - counter width for a modulus, never below 1 bit
package trng_pkg;

   localparam int BYTE_W            = 8;
   localparam int DEF_WARMUP_CYCLES = 64;
   localparam int DEF_SAMPLE_DIV    = 8;
   localparam int DEF_REP_LIMIT     = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WARMUP = 3'd1,
      SAMPLE = 3'd2,
      HOLD   = 3'd3,
      FAULT  = 3'd4
   } trng_state_t;

   // A modulus of 1 would give $clog2 == 0; keep at least one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trng_health_rct.sv
// trng_health_rct: repetition count test on the raw entropy stream.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - restart the test (next sample counts as the first, count=1)
//   sample_stb  - one-cycle strobe: sample_bit is a new raw sample
//   sample_bit  - the raw sample
//   fail        - high in the strobe cycle whose sample makes the run of
//                 identical samples reach REP_LIMIT (combinational, so the
//                 sequencer can leave on that same edge)
module trng_health_rct
   import trng_pkg::*;
#(
   parameter int REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic sample_stb,
   input  logic sample_bit,
   output logic fail
);

   localparam int CNT_W = $clog2(REP_LIMIT + 1);

   logic [CNT_W-1:0] rep_cnt;
   logic             last_bit;
   logic             primed;    // at least one sample seen since clr

   assign fail = sample_stb && primed && (sample_bit == last_bit) &&
                 (rep_cnt == CNT_W'(REP_LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt  <= '0;
         last_bit <= 1'b0;
         primed   <= 1'b0;
      end else if (clr) begin
         rep_cnt  <= '0;
         last_bit <= 1'b0;
         primed   <= 1'b0;
      end else if (sample_stb) begin
         primed   <= 1'b1;
         last_bit <= sample_bit;
         if (primed && (sample_bit == last_bit)) begin
            // Saturate; the sequencer is already in FAULT by then.
            if (rep_cnt != CNT_W'(REP_LIMIT))
               rep_cnt <= rep_cnt + 1'b1;
         end else begin
            rep_cnt <= CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: sequencer for the ring-oscillator entropy source.
// Enables the oscillator, waits out warm-up, samples raw_bit every
// SAMPLE_DIV cycles, optionally von-Neumann debiases, packs bits MSB-first
// into bytes and runs a repetition count health test.
//
// Optional feature: define TRNG_VN_DEBIAS_EN to take samples in pairs
// (10 -> 1, 01 -> 0, 00/11 discarded). Undefined: every sample is a bit.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - level enable, high = produce bytes
//   raw_bit     - oscillator bit, already synchronised to clk
//   osc_en      - ring-oscillator enable
//   rnd_byte    - packed random byte
//   rnd_valid   - rnd_byte valid
//   rnd_ready   - consumer accepts byte
//   busy        - state != IDLE
//   fault       - health test tripped
//
// Handshake: a byte transfers on a clock edge where rnd_valid && rnd_ready.
// Once raised, rnd_valid and rnd_byte hold until that edge (dropping run
// does not retract it); rnd_valid is low in the following cycle.
// All outputs are registered.
module trng_sample_ctrl
   import trng_pkg::*;
#(
   parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
   parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              raw_bit,
   output logic              osc_en,
   output logic [BYTE_W-1:0] rnd_byte,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              fault
);

   localparam int WARM_W = cnt_w(WARMUP_CYCLES);
   localparam int DIV_W  = cnt_w(SAMPLE_DIV);
   localparam int BIT_W  = $clog2(BYTE_W);

   trng_state_t       state;
   logic [WARM_W-1:0] warm_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BYTE_W-1:0] sreg;

   logic              sample_stb;
   logic              health_clr;
   logic              health_fail;
   logic              accept;
   logic              acc_bit;
   logic              byte_done;
   logic [BYTE_W-1:0] next_sreg;

`ifdef TRNG_VN_DEBIAS_EN
   logic pair_phase;   // 0: next sample is s0, 1: next sample is s1
   logic pair_first;   // s0 of the current pair
`endif

   // Sample is gated by run so a falling run never consumes a sample.
   assign sample_stb = (state == SAMPLE) && run &&
                       (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   // The run-length count survives HOLD; it restarts after warm-up.
   assign health_clr = (state == IDLE) || (state == WARMUP) || (state == FAULT);

`ifdef TRNG_VN_DEBIAS_EN
   // Pair 10 yields s0 (1), pair 01 yields s0 (0).
   assign accept  = sample_stb && pair_phase && (pair_first != raw_bit);
   assign acc_bit = pair_first;
`else
   assign accept  = sample_stb;
   assign acc_bit = raw_bit;
`endif

   assign byte_done = accept && (bit_cnt == BIT_W'(BYTE_W - 1));
   assign next_sreg = {sreg[BYTE_W-2:0], acc_bit};

   trng_health_rct #(
      .REP_LIMIT (REP_LIMIT)
   ) u_rct (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (health_clr),
      .sample_stb (sample_stb),
      .sample_bit (raw_bit),
      .fail       (health_fail)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         osc_en    <= 1'b0;
         rnd_byte  <= '0;
         rnd_valid <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
         warm_cnt  <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         sreg      <= '0;
`ifdef TRNG_VN_DEBIAS_EN
         pair_phase <= 1'b0;
         pair_first <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state    <= WARMUP;
                  osc_en   <= 1'b1;
                  busy     <= 1'b1;
                  warm_cnt <= '0;
               end
            end

            WARMUP: begin
               if (!run) begin
                  state    <= IDLE;
                  osc_en   <= 1'b0;
                  busy     <= 1'b0;
                  warm_cnt <= '0;
               end else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                  state    <= SAMPLE;
                  warm_cnt <= '0;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  sreg     <= '0;
`ifdef TRNG_VN_DEBIAS_EN
                  pair_phase <= 1'b0;
`endif
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end

            SAMPLE: begin
               if (!run) begin
                  // Partial byte is discarded; the next run warms up again.
                  state   <= IDLE;
                  osc_en  <= 1'b0;
                  busy    <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  sreg    <= '0;
               end else begin
                  div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
`ifdef TRNG_VN_DEBIAS_EN
                  if (sample_stb) begin
                     pair_phase <= ~pair_phase;
                     if (!pair_phase)
                        pair_first <= raw_bit;
                  end
`endif
                  if (health_fail) begin
                     // Takes priority over a byte completing on this sample.
                     state     <= FAULT;
                     fault     <= 1'b1;
                     osc_en    <= 1'b0;
                     rnd_valid <= 1'b0;
                     bit_cnt   <= '0;
                     sreg      <= '0;
                  end else if (byte_done) begin
                     state     <= HOLD;
                     rnd_byte  <= next_sreg;
                     rnd_valid <= 1'b1;
                     bit_cnt   <= '0;
                     sreg      <= '0;
                  end else if (accept) begin
                     sreg    <= next_sreg;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            HOLD: begin
               // Divider frozen; it wrapped to 0 on the completing sample.
               if (rnd_ready) begin
                  rnd_valid <= 1'b0;
                  if (run) begin
                     state <= SAMPLE;
`ifdef TRNG_VN_DEBIAS_EN
                     pair_phase <= 1'b0;
`endif
                  end else begin
                     state   <= IDLE;
                     osc_en  <= 1'b0;
                     busy    <= 1'b0;
                     div_cnt <= '0;
                  end
               end
            end

            FAULT: begin
               if (!run) begin
                  state   <= IDLE;
                  fault   <= 1'b0;
                  busy    <= 1'b0;
                  div_cnt <= '0;
               end
            end

            default: begin
               state     <= IDLE;
               osc_en    <= 1'b0;
               rnd_valid <= 1'b0;
               busy      <= 1'b0;
               fault     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// tb_trng_sample_ctrl: directed bench for trng_sample_ctrl
// (WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=8). Works in both builds:
// data bits are sent as raw samples or as debias pairs accordingly.
module tb_trng_sample_ctrl;

   localparam int W   = 4;
   localparam int DIV = 2;
   localparam int REP = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic       raw_bit;
   logic       osc_en;
   logic [7:0] rnd_byte;
   logic       rnd_valid;
   logic       rnd_ready;
   logic       busy;
   logic       fault;

   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         checks   = 0;
   int         failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   trng_sample_ctrl #(
      .WARMUP_CYCLES (W),
      .SAMPLE_DIV    (DIV),
      .REP_LIMIT     (REP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .raw_bit   (raw_bit),
      .osc_en    (osc_en),
      .rnd_byte  (rnd_byte),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .busy      (busy),
      .fault     (fault)
   );

   // ---------------- check helpers ----------------
   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%02h required=0x%02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks (all start and end at a negedge) ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Raw value is only correct in the cycle ending at the sample edge.
   task automatic feed_raw(input logic b);
      raw_bit = ~b;
      repeat (DIV - 1) tick();
      raw_bit = b;
      tick();
   endtask

   task automatic send_bit(input logic b);
`ifdef TRNG_VN_DEBIAS_EN
      feed_raw(b);
      feed_raw(~b);
`else
      feed_raw(b);
`endif
   endtask

   task automatic send_byte(input logic [7:0] v, input logic push);
      if (push) exp_q.push_back(v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      check1("valid_after_byte", rnd_valid, 1'b1);
   endtask

   task automatic start_run(input string tag);
      run = 1'b1;
      tick();
      for (int i = 0; i < W; i++) begin
         check1({tag, "_warm_osc_en"}, osc_en, 1'b1);
         check1({tag, "_warm_valid"}, rnd_valid, 1'b0);
         tick();
      end
      check1({tag, "_busy"}, busy, 1'b1);
   endtask

   task automatic handshake();
      rnd_ready = 1'b1;
      tick();
      check1("valid_drop", rnd_valid, 1'b0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && rnd_valid && rnd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte actual=0x%02h required=none (t=%0t)", rnd_byte, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rnd_byte !== mon_exp) begin
                  failures++;
                  $display("FAIL byte actual=0x%02h required=0x%02h (t=%0t)", rnd_byte, mon_exp, $time);
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      checks++;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      run       = 1'b0;
      raw_bit   = 1'b0;
      rnd_ready = 1'b1;
      repeat (2) tick();
      check1("rst_osc_en", osc_en, 1'b0);
      check8("rst_byte", rnd_byte, 8'h00);
      check1("rst_valid", rnd_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_fault", fault, 1'b0);
      rst_n = 1'b1;
      repeat (2) tick();
      check1("idle_busy", busy, 1'b0);
      check1("idle_osc_en", osc_en, 1'b0);

      // 0xA5, then a second byte (0xFF with discard pairs when debiasing)
      start_run("t1");
      send_byte(8'hA5, 1'b1);
      handshake();
`ifdef TRNG_VN_DEBIAS_EN
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 8; i++) begin
         feed_raw(1'b1); feed_raw(1'b1);   // pair 11, discarded
         feed_raw(1'b0); feed_raw(1'b0);   // pair 00, discarded
         send_bit(1'b1);
      end
      check1("valid_after_ff", rnd_valid, 1'b1);
`else
      send_byte(8'hC3, 1'b1);
`endif
      handshake();

      // Consumer stalls for 20 cycles; raw input keeps changing meanwhile.
      rnd_ready = 1'b0;
      send_byte(8'h5A, 1'b1);
      for (int i = 0; i < 20; i++) begin
         check8("hold_byte", rnd_byte, 8'h5A);
         check1("hold_valid", rnd_valid, 1'b1);
         raw_bit = 1'($urandom_range(0, 1));
         tick();
      end
      handshake();
      send_byte(8'h96, 1'b1);
      handshake();

      // Drop run after 5 bits; restart must not carry stale bits.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      run = 1'b0;
      tick();
      check1("drop_osc_en", osc_en, 1'b0);
      check1("drop_busy", busy, 1'b0);
      check1("drop_valid", rnd_valid, 1'b0);
      repeat (3) tick();
      start_run("t5");
      send_byte(8'h81, 1'b1);
      handshake();
      run = 1'b0;
      tick();
      check1("stop_busy", busy, 1'b0);

      // Stuck-at-1 source trips the health test on the 8th sample.
      start_run("t3");
      for (int k = 1; k <= REP; k++) begin
         feed_raw(1'b1);
         if (k == REP - 1) begin
            check1("pre_fault", fault, 1'b0);
            check1("pre_fault_osc_en", osc_en, 1'b1);
         end
      end
      check1("fault", fault, 1'b1);
      check1("fault_osc_en", osc_en, 1'b0);
      check1("fault_valid", rnd_valid, 1'b0);
      check1("fault_busy", busy, 1'b1);
      repeat (3) begin
         tick();
         check1("fault_sticky", fault, 1'b1);
      end
      run = 1'b0;
      tick();
      check1("fault_clear", fault, 1'b0);
      check1("fault_idle_busy", busy, 1'b0);
      check1("fault_idle_osc_en", osc_en, 1'b0);

      // Asynchronous reset while holding 0x3C.
      start_run("t6");
      rnd_ready = 1'b0;
      send_byte(8'h3C, 1'b0);
      check8("pre_reset_byte", rnd_byte, 8'h3C);
      #2;
      rst_n = 1'b0;
      #1;
      check1("areset_valid", rnd_valid, 1'b0);
      check8("areset_byte", rnd_byte, 8'h00);
      check1("areset_osc_en", osc_en, 1'b0);
      check1("areset_busy", busy, 1'b0);
      tick();
      run   = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL bytes_left actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
